// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding and defaults for the UART tx arbiter.
package uart_tx_arbiter_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_OWN = 1'b1} arb_state_t;
    localparam int DEFAULT_TIMEOUT = 4096;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin selector, search starts at ptr+1 mod N.
// Ports: req (request vector), ptr (last owner, lowest priority), win (one-hot winner), idx (winner index).
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] idx
);
    // Scan from farthest to nearest so the nearest requester after ptr overwrites.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                win = '0;
                win[(int'(ptr) + k) % N] = 1'b1;
                idx = PW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART tx FIFO write port between NREQ byte streams, one whole message per grant.
// Ports: clk, rst (async, active-high); req_valid/req_data/req_last/req_ready per requester;
// tx_wdata/tx_wten to the tx FIFO, tx_fifo_full from it; grant (one-hot owner), busy, err_timeout (watchdog pulse).
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_wdata,
    output logic              tx_wten,
    input  logic              tx_fifo_full,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              err_timeout
);
    localparam int PW = $clog2(NREQ);
    arb_state_t      state, state_nxt;
    logic [PW-1:0]   rr_ptr, own_idx, win_idx;
    logic [NREQ-1:0] win;
    logic [15:0]     idle_cntr;
    logic            any_valid, owner_valid, owner_last, xfer, drop;
    uart_tx_arbiter_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .win (win),
        .idx (win_idx)
    );
    // grant is zero outside OWN, so it gates ready by itself.
    always_comb begin
        any_valid   = |req_valid;
        owner_valid = req_valid[own_idx];
        owner_last  = req_last[own_idx];
        busy        = state == ARB_OWN;
        req_ready   = tx_fifo_full ? '0 : grant;
        xfer        = |(req_valid & req_ready);
        tx_wten     = xfer;
        tx_wdata    = req_data[8*own_idx +: 8];
        err_timeout = busy && !owner_valid && idle_cntr == 16'(TIMEOUT - 1);
        drop        = busy && ((xfer && owner_last) || err_timeout);
        state_nxt   = busy ? (drop ? ARB_IDLE : ARB_OWN) : (any_valid ? ARB_OWN : ARB_IDLE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            own_idx   <= '0;
            rr_ptr    <= '0;
            idle_cntr <= '0;
        end else begin
            state <= state_nxt;
            if (!busy && any_valid) begin
                grant   <= win;
                own_idx <= win_idx;
            end else if (drop) begin
                grant  <= '0;
                rr_ptr <= own_idx;
            end
            // Backpressure with valid held neither counts nor clears.
            idle_cntr <= (!busy || drop || xfer) ? '0 : idle_cntr + {15'd0, ~owner_valid};
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a message-level reference model.
module tb_uart_tx_arbiter;
    localparam int NREQ = 2;
    localparam int TIMEOUT = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req_valid, req_last, req_ready, grant;
    logic [8*NREQ-1:0] req_data;
    logic [7:0] tx_wdata;
    logic tx_wten, tx_fifo_full, busy, err_timeout;
    always #5 clk = ~clk;
    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_wdata     (tx_wdata),
        .tx_wten      (tx_wten),
        .tx_fifo_full (tx_fifo_full),
        .grant        (grant),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );
    int checks = 0;
    int errors = 0;
    logic [8:0] qbuf [NREQ][8192];
    int hd [NREQ];
    int tl [NREQ];
    int gap [NREQ];
    int m_owner = -1;
    int m_rr = 0;
    int m_wd = 0;
    int cyc = 0;
    bit rnd = 1'b0;
    logic full_in = 1'b0;
    logic [7:0] tx_log [$];
    int grant_log [$];
    int xfer_cyc = 0;
    int first_xfer_cyc = 0;
    int err_cyc = 0;
    int err_cnt = 0;
    logic [NREQ-1:0] prev_grant = '0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask
    task automatic push(input int r, input logic [7:0] d, input logic l);
        qbuf[r][tl[r]] = {l, d};
        tl[r]++;
    endtask
    function automatic bit all_idle();
        bit ok = (m_owner < 0);
        for (int i = 0; i < NREQ; i++) ok &= (hd[i] == tl[i]);
        return ok;
    endfunction
    // One clock cycle: drive at the negedge, check #1 later, advance the model.
    task automatic tick();
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] eg;
        bit xfer, err, lst;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = (hd[i] != tl[i]) && gap[i] == 0;
            req_data[8*i +: 8] = qbuf[i][hd[i]][7:0];
            req_last[i] = qbuf[i][hd[i]][8];
        end
        req_valid = v;
        tx_fifo_full = full_in;
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        xfer = m_owner >= 0 && v[m_owner] && !full_in;
        err = m_owner >= 0 && !v[m_owner] && m_wd == TIMEOUT - 1;
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("ready", 32'(req_ready), full_in ? 32'd0 : 32'(eg));
        chk("wten", 32'(tx_wten), 32'(xfer));
        chk("err", 32'(err_timeout), 32'(err));
        if (xfer) chk("wdata", 32'(tx_wdata), 32'(qbuf[m_owner][hd[m_owner]][7:0]));
        if (tx_wten) begin
            if (tx_log.size() == 0) first_xfer_cyc = cyc;
            tx_log.push_back(tx_wdata);
            xfer_cyc = cyc;
        end
        if (err_timeout) begin
            err_cyc = cyc;
            err_cnt++;
        end
        if (grant != 0 && prev_grant == 0) grant_log.push_back(grant[1] ? 1 : 0);
        prev_grant = grant;
        for (int i = 0; i < NREQ; i++) if (gap[i] > 0) gap[i]--;
        if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++)
                if (m_owner < 0 && v[(m_rr + k) % NREQ]) m_owner = (m_rr + k) % NREQ;
            m_wd = 0;
        end else if (xfer) begin
            lst = qbuf[m_owner][hd[m_owner]][8];
            hd[m_owner]++;
            gap[m_owner] = !rnd ? 0 : ($urandom_range(0, 9) == 0 ? $urandom_range(15, 20) : $urandom_range(0, 2));
            m_wd = 0;
            if (lst) begin
                m_rr = m_owner;
                m_owner = -1;
            end
        end else if (err) begin
            m_rr = m_owner;
            m_owner = -1;
            m_wd = 0;
        end else if (!v[m_owner]) m_wd++;
        cyc++;
        @(negedge clk);
    endtask
    task automatic run(input int maxc);
        int t = 0;
        while (t < maxc && !all_idle()) begin
            tick();
            t++;
        end
        chk("drain", 32'(all_idle()), 32'd1);
    endtask
    task automatic run_log(input int n, input int maxc);
        int t = 0;
        while (t < maxc && tx_log.size() < n) begin
            tick();
            t++;
        end
        chk("reach", 32'(tx_log.size() >= n), 32'd1);
    endtask
    task automatic check_log(input string tag, input logic [31:0] exp, input int n);
        chk({tag, "_len"}, 32'(tx_log.size()), 32'(n));
        for (int k = 0; k < n && k < tx_log.size(); k++)
            chk(tag, 32'(tx_log[k]), 32'(exp[8*(n-1-k) +: 8]));
    endtask
    initial begin
        int t0, e0, zeros;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
            gap[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_wten", 32'(tx_wten), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        t0 = cyc;
        run(50);
        check_log("single", 32'h00414243, 3);
        chk("single_lat", 32'(first_xfer_cyc - t0), 32'd1);
        chk("single_span", 32'(xfer_cyc - first_xfer_cyc), 32'd2);
        tx_log.delete();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b1);
        push(1, 8'h78, 1'b0);
        push(1, 8'h79, 1'b1);
        run(50);
        check_log("cont", 32'h78794142, 4);
        tx_log.delete();
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        run_log(1, 20);
        full_in = 1'b1;
        e0 = err_cnt;
        repeat (20) tick();
        chk("bp_hold", 32'(tx_log.size()), 32'd1);
        full_in = 1'b0;
        run(50);
        check_log("bp", 32'h00112233, 3);
        chk("bp_err", 32'(err_cnt - e0), 32'd0);
        tx_log.delete();
        push(0, 8'h5a, 1'b0);
        run_log(1, 20);
        push(1, 8'h66, 1'b1);
        e0 = err_cnt;
        t0 = 0;
        while (t0 < 40 && err_cnt == e0) begin
            tick();
            t0++;
        end
        chk("wd_seen", 32'(err_cnt - e0), 32'd1);
        chk("wd_delay", 32'(err_cyc - xfer_cyc), 32'd16);
        grant_log.delete();
        run(50);
        check_log("wd", 32'h00005a66, 2);
        chk("wd_next", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
        grant_log.delete();
        for (int k = 0; k < 5; k++) begin
            push(0, 8'(k), 1'b1);
            push(1, 8'(k + 16), 1'b1);
        end
        run(100);
        chk("fair_n", 32'(grant_log.size()), 32'd10);
        zeros = 0;
        for (int k = 0; k < grant_log.size(); k++) begin
            chk("fair_seq", 32'(grant_log[k]), 32'(k % 2));
            if (grant_log[k] == 0) zeros++;
        end
        chk("fair_eq", 32'(zeros), 32'd5);
        tx_log.delete();
        for (int k = 0; k < 4; k++) push(0, 8'(8'hb0 + k), k == 3);
        run_log(1, 20);
        rst = 1'b1;
        #1;
        chk("rm_grant", 32'(grant), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_ready", 32'(req_ready), 32'd0);
        chk("rm_wten", 32'(tx_wten), 32'd0);
        m_owner = -1;
        m_rr = 0;
        m_wd = 0;
        prev_grant = '0;
        for (int i = 0; i < NREQ; i++) hd[i] = tl[i];
        @(negedge clk);
        rst = 1'b0;
        tx_log.delete();
        grant_log.delete();
        push(0, 8'hc0, 1'b1);
        push(1, 8'hc1, 1'b1);
        run(50);
        check_log("rst_new", 32'h0000c1c0, 2);
        rnd = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (hd[i] == tl[i] && $urandom_range(0, 3) == 0) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
            full_in = ($urandom_range(0, 3) == 0);
            tick();
        end
        rnd = 1'b0;
        full_in = 1'b0;
        run(500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
